// File: rtl/apb_ram_param.sv
// APB slave wrapping a byte-writable word RAM with an optional number of access-phase
// wait states. Reads return registered data; out-of-range addresses complete with pslverr.
module apb_ram_param #(
  parameter int DW          = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [31:0]     paddr,
  input  logic [DW-1:0]   pwdata,
  input  logic [DW/8-1:0] pstrb,
  output logic [DW-1:0]   prdata,
  output logic            pready,
  output logic            pslverr
);

  localparam int NB = DW / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          pwrite_reg, pwrite_next;
  logic          pready_reg, pready_next;
  logic          pslverr_reg, pslverr_next;
  logic [DW-1:0] prdata_reg;

  logic [DW-1:0] mem [DEPTH];

  logic          setup_ph, access_ph, out_of_range;
  logic [AW-1:0] idx;
  logic          enter_resp, resp_write, rd_load, mem_we;

  assign setup_ph     = psel & ~penable;
  assign access_ph    = psel & penable;
  assign out_of_range = (paddr >= 32'(DEPTH));
  assign idx          = paddr[AW-1:0];

  // State register, also holding the registered bus outputs
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 4'd0;
      pwrite_reg  <= 1'b0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      prdata_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pwrite_reg  <= pwrite_next;
      pready_reg  <= pready_next;
      pslverr_reg <= pslverr_next;
      if (rd_load)
        prdata_reg <= out_of_range ? '0 : mem[idx];
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (setup_ph) state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: begin
        if (!psel)
          state_next = S_IDLE;
        else if (penable && cnt_reg == 4'd1)
          state_next = S_RESP;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    cnt_next    = cnt_reg;
    pwrite_next = pwrite_reg;
    enter_resp  = (state_next == S_RESP) && (state_reg != S_RESP);
    // From IDLE the direction has not been latched yet, so take it straight off the bus
    resp_write  = (state_reg == S_IDLE) ? pwrite : pwrite_reg;
    case (state_reg)
      S_IDLE: begin
        if (setup_ph) begin
          cnt_next    = 4'(WAIT_CYCLES);
          pwrite_next = pwrite;
        end
      end
      S_WAIT:  if (access_ph) cnt_next = cnt_reg - 4'd1;
      default: ;
    endcase
    pready_next  = enter_resp;
    pslverr_next = enter_resp & out_of_range;
    rd_load      = enter_resp & ~resp_write;
    mem_we       = (state_reg == S_RESP) & pwrite_reg & ~pslverr_reg;
  end

  // Byte-lane write on the edge leaving RESP; pstrb of zero writes nothing
  always_ff @(posedge pclk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++)
        if (pstrb[i]) mem[idx][i*8 +: 8] <= pwdata[i*8 +: 8];
    end
  end

  assign prdata  = prdata_reg;
  assign pready  = pready_reg;
  assign pslverr = pslverr_reg;

endmodule

// File: doc/apb_ram_param.md
APB_RAM_PARAM -- requirements
Module: apb_ram_param

Interface
REQ-001 Parameter DW, default 32, data width in bits; SHALL be a multiple of 8, range 8..128.
REQ-002 Parameter DEPTH, default 64, number of DW-bit words; SHALL be a power of two, range 2..4096.
REQ-003 Parameter WAIT_CYCLES, default 0, access-phase wait states inserted before pready; range 0..15.
REQ-004 pclk  input  1  sole clock; all state SHALL change on its rising edge, except asynchronous reset.
REQ-005 presetn  input  1  reset; asynchronous assertion, active-low.
REQ-006 psel  input  1  slave select.
REQ-007 penable  input  1  access-phase indicator.
REQ-008 pwrite  input  1  1 = write, 0 = read.
REQ-009 paddr  input  32  word index; byte offsets are not used.
REQ-010 pwdata  input  DW  write data.
REQ-011 pstrb  input  DW/8  write byte-lane enables; bit i covers pwdata[8i+7:8i].
REQ-012 prdata  output  DW  read data, registered.
REQ-013 pready  output  1  transfer-complete strobe, registered.
REQ-014 pslverr  output  1  error response, registered; valid only while pready=1.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-016 In IDLE, an edge sampling psel=1 and penable=0 (setup phase) SHALL load the 4-bit counter with WAIT_CYCLES and latch pwrite.
- Next state: WAIT if WAIT_CYCLES>0, else RESP.
REQ-017 In WAIT, each edge sampling psel=1 and penable=1 SHALL decrement the counter.
- At the edge where counter=1: enter RESP.
REQ-018 In WAIT, an edge sampling psel=0 SHALL return the FSM to IDLE.
- No memory access occurs; pready stays 0.
REQ-019 On entry to RESP, pready SHALL become 1.
- pslverr SHALL become 1 if paddr>=DEPTH, else 0.
REQ-020 Setup-to-pready latency SHALL be 1+WAIT_CYCLES cycles.
- WAIT_CYCLES=0: pready=1 in the first access cycle, giving a zero-wait APB transfer.
REQ-021 Read entering RESP:
- In range: prdata SHALL load mem[paddr[log2(DEPTH)-1:0]].
- Out of range: prdata SHALL load 0.
REQ-022 Write in range: memory SHALL be updated on the edge leaving RESP.
- Only byte lanes with pstrb[i]=1 are written; other lanes keep old data.
REQ-023 Out-of-range writes and writes with pstrb=0 SHALL leave memory unchanged.
- pstrb=0 SHALL NOT raise pslverr.
REQ-024 RESP SHALL last exactly one cycle; the next edge SHALL return to IDLE with pready=0 and pslverr=0.
REQ-025 prdata SHALL hold its last value until the next read enters RESP; writes SHALL NOT alter prdata.
REQ-026 Back-to-back transfers SHALL be accepted: the setup phase in the cycle after RESP is sampled by IDLE.
- No dead cycle is inserted.
REQ-027 Read-after-write to the same address SHALL return the newly written data.
REQ-028 pslverr SHALL be 0 whenever pready=0.

Reset
REQ-029 presetn=0 SHALL asynchronously force the following, whatever the current state:
- FSM=IDLE, counter=0, pready=0, pslverr=0, prdata=0.
REQ-030 Reset SHALL NOT clear memory contents; contents are undefined until written.
REQ-031 A reset asserted in WAIT or RESP SHALL abort the transfer with no memory write.
REQ-032 Leaving reset SHALL be synchronous: the first setup phase is sampled on the first edge with presetn=1.

Verification
REQ-033 DW=32, WAIT_CYCLES=0: write 0xDEADBEEF to addr 5 with pstrb=0xF, then read addr 5.
- pready high in the first access cycle, prdata=0xDEADBEEF, pslverr=0.
REQ-034 Partial write: mem[3]=0x11223344, then write 0xAABBCCDD with pstrb=0x5, then read addr 3.
- prdata=0x11BB33DD.
REQ-035 Read of addr DEPTH (64) -> pslverr=1, prdata=0.
- Write to addr 100 -> pslverr=1, and mem[36] (aliased index) unchanged.
REQ-036 WAIT_CYCLES=3: pready rises exactly 4 cycles after setup.
- Back-to-back write/read to addr 7 returns the written data.
REQ-037 Assert presetn=0 during WAIT of a write to addr 2 -> pready=0, prdata=0 immediately.
- A later read of addr 2 returns its prior value.
REQ-038 Drop psel during WAIT -> FSM returns to IDLE, no pready pulse, memory unchanged.
